// File: rtl/stack_cpu_pkg.sv
// Shared encodings for the multicycle stack CPU: instruction fields, fault codes, FSM states.
package stack_cpu_pkg;

  localparam logic [1:0] TypePush = 2'b00;
  localparam logic [1:0] TypeAlu  = 2'b01;
  localparam logic [1:0] TypeJump = 2'b10;
  localparam logic [1:0] TypeMisc = 2'b11;

  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd1;
  localparam logic [3:0] AluAnd = 4'd2;
  localparam logic [3:0] AluOr  = 4'd3;
  localparam logic [3:0] AluXor = 4'd4;
  localparam logic [3:0] AluAdc = 4'd5;
  localparam logic [3:0] AluNot = 4'd6;
  localparam logic [3:0] AluShl = 4'd7;
  localparam logic [3:0] AluShr = 4'd8;

  localparam logic [2:0] JmpAlways  = 3'd0;
  localparam logic [2:0] JmpZero    = 3'd1;
  localparam logic [2:0] JmpNonZero = 3'd2;
  localparam logic [2:0] JmpNeg     = 3'd3;
  localparam logic [2:0] JmpCarry   = 3'd4;

  localparam logic [3:0] MiscNop  = 4'd0;
  localparam logic [3:0] MiscDup  = 4'd1;
  localparam logic [3:0] MiscDrop = 4'd2;
  localparam logic [3:0] MiscSwap = 4'd3;
  localparam logic [3:0] MiscHalt = 4'd4;

  localparam logic [1:0] FaultNone      = 2'd0;
  localparam logic [1:0] FaultOverflow  = 2'd1;
  localparam logic [1:0] FaultUnderflow = 2'd2;
  localparam logic [1:0] FaultIllegal   = 2'd3;

  typedef enum logic [1:0] {StFetch, StExec, StHalt, StFault} state_e;

endpackage

// File: rtl/datastack.sv
// Shift-register data stack: entry 0 is the top, so top/next are fixed taps.
// Limits are not checked here; the caller only issues legal operations.
module datastack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic             swap,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next_word,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CntW-1:0]  count_q;

  // pop together with replace is the binary-op form: drop one, overwrite the new top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
    end else if (push) begin
      mem_q[0] <= wdata;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
      count_q <= count_q + 1'b1;
    end else if (pop) begin
      mem_q[0] <= replace ? wdata : mem_q[1];
      for (int i = 1; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
      mem_q[DEPTH-1] <= '0;
      count_q <= count_q - 1'b1;
    end else if (replace) begin
      mem_q[0] <= wdata;
    end else if (swap) begin
      mem_q[0] <= mem_q[1];
      mem_q[1] <= mem_q[0];
    end
  end

  assign top       = mem_q[0];
  assign next_word = mem_q[1];
  assign count     = count_q;

endmodule

// File: rtl/stack_cpu_core.sv
// Multicycle stack CPU: FETCH over a valid/req handshake, one-cycle EXEC, terminal HALT/FAULT.
module stack_cpu_core
  import stack_cpu_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 16,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic              i_clock,
  input  logic              i_rst_n,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic              o_imem_req,
  input  logic              i_imem_valid,
  input  logic [WIDTH+1:0]  i_imem_data,
  output logic              o_halted,
  output logic              o_fault,
  output logic [1:0]        o_fault_code,
  output logic [WIDTH-1:0]  o_top,
  output logic [CntW-1:0]   o_depth,
  output logic              o_carry
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [WIDTH+1:0]  instr_q;
  logic              carry_q, req_q, halted_q, fault_q;
  logic [1:0]        code_q;

  logic [WIDTH-1:0]  tos, nos, field, alu_res, wdata;
  logic [CntW-1:0]   depth;
  logic [1:0]        typ, need, fault_code;
  logic [3:0]        op;
  logic [2:0]        cond;
  logic              grow, illegal, taken, alu_carry, is_halt, exec_ok;
  logic              push_raw, pop_raw, repl_raw, swap_raw;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    typ       = instr_q[WIDTH+1:WIDTH];
    field     = instr_q[WIDTH-1:0];
    op        = field[3:0];
    cond      = field[2:0];
    need      = 2'd0;
    grow      = 1'b0;
    illegal   = 1'b0;
    taken     = 1'b0;
    is_halt   = 1'b0;
    alu_res   = tos;
    alu_carry = carry_q;
    push_raw  = 1'b0;
    pop_raw   = 1'b0;
    repl_raw  = 1'b0;
    swap_raw  = 1'b0;
    wdata     = field;
    unique case (typ)
      TypePush: begin
        grow     = 1'b1;
        push_raw = 1'b1;
      end
      TypeAlu: begin
        wdata = alu_res;
        case (op)
          AluAdd: {alu_carry, alu_res} = {1'b0, nos} + {1'b0, tos};
          // carry out of a + ~b + 1 is the "no borrow" flag
          AluSub: {alu_carry, alu_res} = {1'b0, nos} + {1'b0, ~tos} + (WIDTH+1)'(1);
          AluAnd: alu_res = nos & tos;
          AluOr:  alu_res = nos | tos;
          AluXor: alu_res = nos ^ tos;
          AluAdc: {alu_carry, alu_res} = {1'b0, nos} + {1'b0, tos} + (WIDTH+1)'(carry_q);
          AluNot: alu_res = ~tos;
          AluShl: {alu_carry, alu_res} = {tos, 1'b0};
          AluShr: {alu_res, alu_carry} = {1'b0, tos};
          default: illegal = 1'b1;
        endcase
        wdata = alu_res;
        if (op <= AluAdc) begin
          need     = 2'd2;
          pop_raw  = 1'b1;
          repl_raw = 1'b1;
        end else if (op <= AluShr) begin
          need     = 2'd1;
          repl_raw = 1'b1;
        end
      end
      TypeJump: begin
        case (cond)
          JmpAlways:  taken = 1'b1;
          JmpZero:    begin need = 2'd1; taken = (tos == '0); end
          JmpNonZero: begin need = 2'd1; taken = (tos != '0); end
          JmpNeg:     begin need = 2'd1; taken = tos[WIDTH-1]; end
          JmpCarry:   taken = carry_q;
          default:    illegal = 1'b1;
        endcase
      end
      TypeMisc: begin
        case (op)
          MiscNop:  ;
          MiscDup:  begin need = 2'd1; grow = 1'b1; push_raw = 1'b1; wdata = tos; end
          MiscDrop: begin need = 2'd1; pop_raw = 1'b1; end
          MiscSwap: begin need = 2'd2; swap_raw = 1'b1; end
          MiscHalt: is_halt = 1'b1;
          default:  illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    if (illegal)                                fault_code = FaultIllegal;
    else if (CntW'(need) > depth)               fault_code = FaultUnderflow;
    else if (grow && (depth == CntW'(DEPTH)))   fault_code = FaultOverflow;
    else                                        fault_code = FaultNone;
  end

  assign exec_ok = (state_q == StExec) && (fault_code == FaultNone);
  assign pc_d    = taken ? field[WIDTH-1 -: ADDR_W] : pc_q + ADDR_W'(1);

  datastack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (i_clock),
    .rst_n     (i_rst_n),
    .push      (exec_ok & push_raw),
    .pop       (exec_ok & pop_raw),
    .replace   (exec_ok & repl_raw),
    .swap      (exec_ok & swap_raw),
    .wdata     (wdata),
    .top       (tos),
    .next_word (nos),
    .count     (depth)
  );

  // req_q resets low so the request drops asynchronously and reappears one cycle after release
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StFetch;
      pc_q     <= '0;
      instr_q  <= '0;
      carry_q  <= 1'b0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= FaultNone;
    end else begin
      unique case (state_q)
        StFetch: begin
          req_q <= 1'b1;
          if (req_q && i_imem_valid) begin
            instr_q <= i_imem_data;
            req_q   <= 1'b0;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (fault_code != FaultNone) begin
            fault_q <= 1'b1;
            code_q  <= fault_code;
            state_q <= StFault;
          end else begin
            pc_q    <= pc_d;
            carry_q <= alu_carry;
            if (is_halt) begin
              halted_q <= 1'b1;
              state_q  <= StHalt;
            end else begin
              req_q   <= 1'b1;
              state_q <= StFetch;
            end
          end
        end
        default: req_q <= 1'b0;
      endcase
    end
  end

  assign o_imem_addr  = pc_q;
  assign o_imem_req   = req_q;
  assign o_halted     = halted_q;
  assign o_fault      = fault_q;
  assign o_fault_code = code_q;
  assign o_top        = tos;
  assign o_depth      = depth;
  assign o_carry      = carry_q;

endmodule

// File: tb/tb_stack_cpu_core.sv
// Directed and random programs run against an instruction-level reference model of the CPU.
module tb_stack_cpu_core;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] imem_addr;
  logic          imem_req;
  logic          imem_valid;
  logic [W+1:0]  imem_data;
  logic          halted, fault, carry;
  logic [1:0]    fault_code;
  logic [W-1:0]  top;
  logic [4:0]    depth;

  stack_cpu_core #(
    .WIDTH  (W),
    .DEPTH  (D),
    .ADDR_W (AW)
  ) dut (
    .i_clock      (clk),
    .i_rst_n      (rst_n),
    .o_imem_addr  (imem_addr),
    .o_imem_req   (imem_req),
    .i_imem_valid (imem_valid),
    .i_imem_data  (imem_data),
    .o_halted     (halted),
    .o_fault      (fault),
    .o_fault_code (fault_code),
    .o_top        (top),
    .o_depth      (depth),
    .o_carry      (carry)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0, fails = 0, cyc = 0;
  logic [W+1:0]  prog [int];
  logic [W-1:0]  m_stk [$];
  logic [AW-1:0] m_pc;
  logic          m_carry, m_halt;
  logic [1:0]    m_code;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] i_push(input logic [W-1:0] v); return {2'b00, v}; endfunction
  function automatic logic [W+1:0] i_alu(input logic [3:0] op); return {2'b01, 12'h0, op}; endfunction
  function automatic logic [W+1:0] i_jmp(input logic [2:0] c, input logic [AW-1:0] t);
    return {2'b10, t, 5'h0, c};
  endfunction
  function automatic logic [W+1:0] i_misc(input logic [3:0] m); return {2'b11, 12'h0, m}; endfunction

  function automatic logic [W+1:0] rand_instr();
    int r = $urandom_range(0, 99);
    if (r < 35) return i_push(W'($urandom));
    if (r < 65) return i_alu(4'($urandom_range(0, 8)));
    if (r < 73) return i_jmp(3'($urandom_range(0, 4)), AW'($urandom));
    if (r < 93) return i_misc(4'($urandom_range(0, 3)));
    if (r < 95) return i_misc(4'd4);
    if (r < 97) return i_alu(4'($urandom_range(9, 15)));
    if (r < 98) return i_jmp(3'($urandom_range(5, 7)), AW'($urandom));
    return i_misc(4'($urandom_range(5, 15)));
  endfunction

  function automatic logic [W+1:0] fetch_word(input logic [AW-1:0] a, input bit rand_fill);
    if (!prog.exists(int'(a))) prog[int'(a)] = rand_fill ? rand_instr() : i_misc(4'd4);
    return prog[int'(a)];
  endfunction

  task automatic model_reset();
    m_stk.delete();
    m_pc = '0; m_carry = 1'b0; m_halt = 1'b0; m_code = 2'd0;
  endtask

  task automatic model_step(input logic [W+1:0] ins);
    logic [1:0] t; logic [W-1:0] f, a, b, r, tp; logic [31:0] s;
    int need; bit grow, ill, taken; logic [AW-1:0] npc;
    t = ins[W+1:W]; f = ins[W-1:0]; need = 0; grow = 0; ill = 0; taken = 0;
    case (t)
      2'd0: grow = 1;
      2'd1: if (f[3:0] <= 5) need = 2; else if (f[3:0] <= 8) need = 1; else ill = 1;
      2'd2: if (f[2:0] >= 5) ill = 1; else if (f[2:0] >= 1 && f[2:0] <= 3) need = 1;
      default: case (f[3:0])
        4'd0, 4'd4: ;
        4'd1: begin need = 1; grow = 1; end
        4'd2: need = 1;
        4'd3: need = 2;
        default: ill = 1;
      endcase
    endcase
    if (ill) m_code = 2'd3;
    else if (need > m_stk.size()) m_code = 2'd2;
    else if (grow && m_stk.size() == D) m_code = 2'd1;
    if (m_code != 2'd0) return;
    npc = m_pc + 1'b1;
    tp = (m_stk.size() > 0) ? m_stk[0] : '0;
    case (t)
      2'd0: m_stk.push_front(f);
      2'd1: begin
        if (f[3:0] <= 5) begin
          b = m_stk.pop_front(); a = m_stk.pop_front();
          case (f[3:0])
            4'd0: begin s = 32'(a) + 32'(b); r = s[15:0]; m_carry = s[16]; end
            4'd1: begin r = a - b; m_carry = (a >= b); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: begin s = 32'(a) + 32'(b) + 32'(m_carry); r = s[15:0]; m_carry = s[16]; end
          endcase
          m_stk.push_front(r);
        end else begin
          b = m_stk[0];
          case (f[3:0])
            4'd6: r = ~b;
            4'd7: begin r = b << 1; m_carry = b[15]; end
            default: begin r = b >> 1; m_carry = b[0]; end
          endcase
          m_stk[0] = r;
        end
      end
      2'd2: begin
        case (f[2:0])
          3'd0: taken = 1;
          3'd1: taken = (tp == 0);
          3'd2: taken = (tp != 0);
          3'd3: taken = tp[15];
          default: taken = m_carry;
        endcase
        if (taken) npc = f[W-1 -: AW];
      end
      default: case (f[3:0])
        4'd1: m_stk.push_front(tp);
        4'd2: void'(m_stk.pop_front());
        4'd3: begin a = m_stk[0]; m_stk[0] = m_stk[1]; m_stk[1] = a; end
        4'd4: m_halt = 1'b1;
        default: ;
      endcase
    endcase
    m_pc = npc;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_top"}, top, (m_stk.size() > 0) ? m_stk[0] : 16'h0);
    check({tag, "_depth"}, depth, m_stk.size());
    check({tag, "_carry"}, carry, m_carry);
    check({tag, "_halted"}, halted, m_halt);
    check({tag, "_fault"}, fault, m_code != 2'd0);
    check({tag, "_code"}, fault_code, m_code);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_code"}, fault_code, 0);
    check({tag, "_top"}, top, 0);
    check({tag, "_depth"}, depth, 0);
    check({tag, "_carry"}, carry, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("in_reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  // Serves fetches with fixed or random wait, stepping the model once per accepted instruction.
  task automatic run_prog(input int max_instr, input int fixed_wait, input bit rand_fill);
    int w, guard; logic [AW-1:0] a; logic [W+1:0] ins;
    cyc = 0; guard = 0;
    while (imem_req !== 1'b1 && guard < 8) begin
      imem_valid = 1'($urandom); imem_data = (W+2)'($urandom);
      @(negedge clk); guard++;
    end
    check("req_start", imem_req, 1);
    if (imem_req !== 1'b1) return;
    for (int n = 0; n < max_instr && !m_halt && m_code == 0; n++) begin
      check("fetch_addr", imem_addr, m_pc);
      a = imem_addr;
      w = (fixed_wait < 0) ? $urandom_range(0, 3) : fixed_wait;
      for (int k = 0; k < w; k++) begin
        imem_valid = 1'b0; imem_data = (W+2)'($urandom);
        @(negedge clk); cyc++;
        check("wait_addr", imem_addr, a);
        check("wait_req", imem_req, 1);
      end
      ins = fetch_word(a, rand_fill);
      imem_valid = 1'b1; imem_data = ins;
      @(negedge clk); cyc++;
      check("exec_req", imem_req, 0);
      imem_valid = 1'($urandom); imem_data = (W+2)'($urandom);
      @(negedge clk); cyc++;
      model_step(ins);
      check_status("step");
      check("next_req", imem_req, !(m_halt || m_code != 0));
    end
  endtask

  task automatic check_terminal();
    repeat (3) begin
      imem_valid = 1'b1; imem_data = (W+2)'($urandom);
      @(negedge clk);
      check("term_req", imem_req, 0);
      check_status("term");
    end
    imem_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; imem_valid = 1'b0; imem_data = '0;
    model_reset();
    #1;
    check_reset_vals("async_reset");
    @(negedge clk);

    // zero-wait arithmetic
    do_reset(); prog.delete();
    prog[0] = i_push(16'd5); prog[1] = i_push(16'd3); prog[2] = i_alu(4'd0); prog[3] = i_misc(4'd4);
    run_prog(10, 0, 0);
    check("add_top", top, 8); check("add_depth", depth, 1); check("add_carry", carry, 0);
    check("add_halted", halted, 1); check("add_cycles", cyc, 8);
    check_terminal();

    // carry with 3-cycle wait
    do_reset(); prog.delete();
    prog[0] = i_push(16'hFFFF); prog[1] = i_push(16'd1); prog[2] = i_alu(4'd0);
    run_prog(3, 3, 0);
    check("carry_top", top, 0); check("carry_flag", carry, 1);

    // conditional jump taken / not taken
    do_reset(); prog.delete();
    prog[0] = i_push(16'd0); prog[1] = i_jmp(3'd1, 8'h10);
    run_prog(2, 0, 0);
    check("jz_taken_addr", imem_addr, 8'h10);
    do_reset(); prog.delete();
    prog[0] = i_push(16'd1); prog[1] = i_jmp(3'd1, 8'h10);
    run_prog(2, 1, 0);
    check("jz_fall_addr", imem_addr, 8'h02);

    // overflow
    do_reset(); prog.delete();
    for (int i = 0; i <= D; i++) prog[i] = i_push(16'(i + 100));
    run_prog(D + 4, 0, 0);
    check("ovf_code", fault_code, 1); check("ovf_depth", depth, D);
    check("ovf_pc", imem_addr, D); check("ovf_req", imem_req, 0);
    check_terminal();

    // underflow, then illegal with a retained PUSH
    do_reset(); prog.delete();
    prog[0] = i_alu(4'd0);
    run_prog(2, 0, 0);
    check("unf_code", fault_code, 2); check("unf_pc", imem_addr, 0);
    do_reset(); prog.delete();
    prog[0] = i_push(16'd7); prog[1] = i_alu(4'd12);
    run_prog(3, 2, 0);
    check("ill_code", fault_code, 3); check("ill_top", top, 7); check("ill_depth", depth, 1);
    check("ill_pc", imem_addr, 1);
    check_terminal();

    // reset during a fetch wait at PC=7
    do_reset(); prog.delete();
    for (int i = 0; i < 7; i++) prog[i] = i_misc(4'd0);
    run_prog(7, 0, 0);
    imem_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_addr", imem_addr, 7); check("pre_rst_req", imem_req, 1);
    #2 rst_n = 1'b0; imem_valid = 1'b1; imem_data = i_push(16'hBEEF);
    #1 check_reset_vals("mid_reset");
    repeat (2) @(negedge clk);
    prog.delete(); prog[0] = i_push(16'd9); prog[1] = i_misc(4'd4);
    rst_n = 1'b1; model_reset();
    check_reset_vals("post_release");
    @(negedge clk);
    check("first_req", imem_req, 1); check("first_addr", imem_addr, 0);
    run_prog(3, 0, 0);
    check("rst_prog_top", top, 9); check("rst_prog_halt", halted, 1);

    // random programs with random wait states
    for (int p = 0; p < 10; p++) begin
      do_reset(); prog.delete();
      run_prog(60, -1, 1);
      if (m_halt || m_code != 0) check_terminal();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
